// File: rtl/seq_uart_pkg.sv
// seq_uart_pkg: shared types, constants and helpers for the serial reporting stage.
// Build option SEQ_UART_LZS_EN (used by seq_uart_tx) suppresses leading zeros.
package seq_uart_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      SEND    = 2'd2
   } state_e;

   localparam logic [7:0] ASCII_ZERO = 8'h30;
   localparam logic [7:0] ASCII_CR   = 8'h0D;
   localparam logic [7:0] ASCII_LF   = 8'h0A;
   localparam int         FRAME_BITS = 10;
   localparam int         MSG_CHARS  = 5;

   // Double-dabble correction: a digit of 5 or more gets 3 added before the shift.
   function automatic logic [3:0] dabble_adj(input logic [3:0] d);
      return (d >= 4'd5) ? (d + 4'd3) : d;
   endfunction

   // Character at message position idx: hundreds, tens, ones, CR, LF.
   function automatic logic [7:0] msg_char(input logic [2:0] idx, input logic [11:0] bcd);
      logic [7:0] c;
      case (idx)
         3'd0:    c = ASCII_ZERO + {4'h0, bcd[11:8]};
         3'd1:    c = ASCII_ZERO + {4'h0, bcd[7:4]};
         3'd2:    c = ASCII_ZERO + {4'h0, bcd[3:0]};
         3'd3:    c = ASCII_CR;
         default: c = ASCII_LF;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/seq_uart_tx_bin2bcd.sv
// bin2bcd_seq: iterative 8-bit binary to 3-digit BCD converter (one shift-add-3
// step per clock, 8 steps). done_o pulses one cycle after the last step and
// bcd_o holds its value until the next start.
module bin2bcd_seq
   import seq_uart_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic [7:0]  bin_i,
   output logic        done_o,
   output logic [11:0] bcd_o
);

   // {hundreds, tens, ones, remaining binary}
   logic [19:0] sh_q, sh_d;
   logic [19:0] adj;
   logic [2:0]  cnt_q, cnt_d;
   logic        active_q, active_d;
   logic        done_q, done_d;

   // Correct each BCD digit before the left shift.
   always_comb begin
      adj = {dabble_adj(sh_q[19:16]), dabble_adj(sh_q[15:12]),
             dabble_adj(sh_q[11:8]), sh_q[7:0]};
   end

   // Iteration control: load on start, then shift eight times.
   always_comb begin
      sh_d     = sh_q;
      cnt_d    = cnt_q;
      active_d = active_q;
      done_d   = 1'b0;
      if (start_i) begin
         sh_d     = {12'h000, bin_i};
         cnt_d    = 3'd0;
         active_d = 1'b1;
      end else if (active_q) begin
         sh_d  = {adj[18:0], 1'b0};
         cnt_d = cnt_q + 3'd1;
         if (cnt_q == 3'd7) begin
            active_d = 1'b0;
            done_d   = 1'b1;
         end
      end
   end

   // Converter state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_q     <= '0;
         cnt_q    <= '0;
         active_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         sh_q     <= sh_d;
         cnt_q    <= cnt_d;
         active_q <= active_d;
         done_q   <= done_d;
      end
   end

   assign done_o = done_q;
   assign bcd_o  = sh_q[19:8];

endmodule

// File: rtl/seq_uart_tx.sv
// seq_uart_tx: converts each accepted 8-bit value to ASCII decimal and sends it
// as 8N1 UART characters followed by CR LF. One pending value is buffered;
// strobes that find the buffer full are dropped and flagged in overrun.
// Build option SEQ_UART_LZS_EN: suppress leading zeros (ones digit always sent).
module seq_uart_tx
   import seq_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] value_in,
   input  logic       value_valid,
   output logic       ready,
   output logic       tx,
   output logic       busy,
   output logic       overrun
);

   localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0]        BIT_LAST  = 4'(FRAME_BITS - 1);
   localparam logic [2:0]        CHAR_LAST = 3'(MSG_CHARS - 1);

   state_e            state_q, state_d;
   logic              pend_full_q, pend_full_d;
   logic [7:0]        pend_val_q, pend_val_d;
   logic              overrun_q, overrun_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [3:0]        bit_q, bit_d;
   logic [2:0]        char_q, char_d;
   logic [8:0]        shift_q, shift_d;
   logic              tx_q, tx_d;

   logic              conv_start;
   logic              conv_done;
   logic [11:0]       bcd;
   logic              baud_wrap;
   logic              frame_end;
   logic              last_char;
   logic [2:0]        first_idx;
   logic [2:0]        next_idx;

   bin2bcd_seq u_bcd (
      .clk     (clk),
      .rst     (reset),
      .start_i (conv_start),
      .bin_i   (pend_val_q),
      .done_o  (conv_done),
      .bcd_o   (bcd)
   );

   // Frame timing decodes and the position of the first character to send.
   always_comb begin
      baud_wrap = (baud_q == BAUD_LAST);
      frame_end = baud_wrap && (bit_q == BIT_LAST);
      last_char = (char_q == CHAR_LAST);
      next_idx  = char_q + 3'd1;
`ifdef SEQ_UART_LZS_EN
      if (bcd[11:8] != 4'd0)
         first_idx = 3'd0;
      else if (bcd[7:4] != 4'd0)
         first_idx = 3'd1;
      else
         first_idx = 3'd2;
`else
      first_idx = 3'd0;
`endif
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pend_full_q) state_d = CONVERT;
         CONVERT: if (conv_done) state_d = SEND;
         SEND:    if (frame_end && last_char) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: busy for the whole message, converter kick when pending is consumed.
   always_comb begin
      busy       = (state_q != IDLE);
      conv_start = (state_q == IDLE) && pend_full_q;
   end

   // Pending register and sticky overrun; consume and load never coincide
   // because loading requires the register to be empty.
   always_comb begin
      pend_full_d = pend_full_q;
      pend_val_d  = pend_val_q;
      overrun_d   = overrun_q;
      if (conv_start)
         pend_full_d = 1'b0;
      if (value_valid) begin
         if (!pend_full_q) begin
            pend_full_d = 1'b1;
            pend_val_d  = value_in;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   // Serialiser: shift_q holds the data bits still to go plus the stop bit.
   always_comb begin
      baud_d  = baud_q;
      bit_d   = bit_q;
      char_d  = char_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      case (state_q)
         CONVERT: begin
            if (conv_done) begin
               baud_d  = '0;
               bit_d   = 4'd0;
               char_d  = first_idx;
               shift_d = {1'b1, msg_char(first_idx, bcd)};
               tx_d    = 1'b0;
            end
         end
         SEND: begin
            if (baud_wrap) begin
               baud_d = '0;
               if (bit_q == BIT_LAST) begin
                  bit_d = 4'd0;
                  if (last_char) begin
                     tx_d = 1'b1;
                  end else begin
                     char_d  = next_idx;
                     shift_d = {1'b1, msg_char(next_idx, bcd)};
                     tx_d    = 1'b0;
                  end
               end else begin
                  bit_d   = bit_q + 4'd1;
                  tx_d    = shift_q[0];
                  shift_d = {1'b1, shift_q[8:1]};
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: begin
            baud_d = '0;
            bit_d  = 4'd0;
            tx_d   = 1'b1;
         end
      endcase
   end

   // Datapath registers; reset returns the line to idle high at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_full_q <= 1'b0;
         pend_val_q  <= 8'h00;
         overrun_q   <= 1'b0;
         baud_q      <= '0;
         bit_q       <= 4'd0;
         char_q      <= 3'd0;
         shift_q     <= 9'h1FF;
         tx_q        <= 1'b1;
      end else begin
         pend_full_q <= pend_full_d;
         pend_val_q  <= pend_val_d;
         overrun_q   <= overrun_d;
         baud_q      <= baud_d;
         bit_q       <= bit_d;
         char_q      <= char_d;
         shift_q     <= shift_d;
         tx_q        <= tx_d;
      end
   end

   assign ready   = !pend_full_q;
   assign tx      = tx_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_seq_uart_tx.sv
// tb_seq_uart_tx: scoreboard bench. A timing-level model predicts ready, busy,
// overrun and the byte stream (with start times); a UART receiver process
// decodes tx and checks each received byte against the expected queue.
module tb_seq_uart_tx;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] value_in;
   logic       value_valid;
   logic       ready, tx, busy, overrun;

   seq_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
      .clk         (clk),
      .reset       (reset),
      .value_in    (value_in),
      .value_valid (value_valid),
      .ready       (ready),
      .tx          (tx),
      .busy        (busy),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] b;
      longint     start;
   } exp_t;
   exp_t exp_q[$];

   int total = 0;
   int bad   = 0;

   // model state
   bit         m_pend = 1'b0;
   logic [7:0] m_val  = 8'h00;
   bit         m_ovr  = 1'b0;
   longint     m_end  = 0;
   longint     m_bstart = 0;

   function automatic void chk(input string name, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   // Engine takes pending at edge t: first start bit at t+9, 10*CPB cycles per char.
   function automatic void model_consume(input longint t, input logic [7:0] v);
      logic [7:0] chars[$];
      int h, te, o;
      h  = int'(v) / 100;
      te = (int'(v) / 10) % 10;
      o  = int'(v) % 10;
`ifdef SEQ_UART_LZS_EN
      if (h != 0) chars.push_back(8'(48 + h));
      if (h != 0 || te != 0) chars.push_back(8'(48 + te));
`else
      chars.push_back(8'(48 + h));
      chars.push_back(8'(48 + te));
`endif
      chars.push_back(8'(48 + o));
      chars.push_back(8'h0D);
      chars.push_back(8'h0A);
      for (int k = 0; k < chars.size(); k++)
         exp_q.push_back('{chars[k], t + 9 + longint'(k) * 10 * CPB});
      m_bstart = t;
      m_end    = t + 9 + longint'(chars.size()) * 10 * CPB;
   endfunction

   function automatic void model_edge(input longint t, input bit vv, input logic [7:0] vd);
      bit rb;
      rb = !m_pend;
      if (m_pend && t > m_end) begin
         m_pend = 1'b0;
         model_consume(t, m_val);
      end
      if (vv) begin
         if (rb) begin
            m_pend = 1'b1;
            m_val  = vd;
         end else begin
            m_ovr = 1'b1;
         end
      end
   endfunction

   task automatic tick(input bit vv, input logic [7:0] vd);
      value_valid = vv;
      value_in    = vd;
      @(posedge clk);
      @(negedge clk);
      value_valid = 1'b0;
      model_edge(cyc, vv, vd);
      chk("ready", longint'(ready), longint'(!m_pend));
      chk("busy", longint'(busy), (cyc >= m_bstart && cyc < m_end) ? 1 : 0);
      chk("overrun", longint'(overrun), longint'(m_ovr));
   endtask

   task automatic do_reset();
      #1 reset = 1'b1;
      #1;
      chk("rst_tx", longint'(tx), 1);
      chk("rst_busy", longint'(busy), 0);
      chk("rst_ready", longint'(ready), 1);
      chk("rst_overrun", longint'(overrun), 0);
      exp_q.delete();
      m_pend = 1'b0;
      m_ovr  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset    = 1'b0;
      m_end    = cyc;
      m_bstart = cyc;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((m_pend || cyc < m_end) && n < 3000) begin
         tick(1'b0, 8'h00);
         n++;
      end
      chk("idle_timeout", (n < 3000) ? 1 : 0, 1);
      repeat (3) tick(1'b0, 8'h00);
   endtask

   task automatic wait_tx_low();
      int n = 0;
      while (tx !== 1'b0 && n < 40) begin
         tick(1'b0, 8'h00);
         n++;
      end
      chk("tx_low_before_reset", longint'(tx), 0);
   endtask

   // UART receiver / scoreboard monitor: samples mid-bit, pops expected bytes.
   initial begin : decoder
      bit         act;
      longint     st;
      longint     off;
      int         idx;
      logic [9:0] bits;
      exp_t       e;
      act  = 1'b0;
      st   = 0;
      bits = '0;
      forever begin
         @(negedge clk);
         if (reset === 1'b1) begin
            act = 1'b0;
         end else if (!act) begin
            if (tx === 1'b0) begin
               act = 1'b1;
               st  = cyc;
            end
         end else begin
            off = cyc - st;
            if ((off % CPB) == CPB / 2) begin
               idx = int'(off / CPB);
               bits[idx] = tx;
               if (idx == 9) begin
                  act = 1'b0;
                  if (exp_q.size() == 0) begin
                     total++;
                     bad++;
                     $display("FAIL unexpected_byte: got 0x%02h expected none (cycle %0d)", bits[8:1], cyc);
                  end else begin
                     e = exp_q.pop_front();
                     chk("byte", longint'(bits[8:1]), longint'(e.b));
                     chk("start_cycle", st, e.start);
                     chk("start_bit", longint'(bits[0]), 0);
                     chk("stop_bit", longint'(bits[9]), 1);
                     $display("rx byte 0x%02h at cycle %0d (expected 0x%02h at %0d)", bits[8:1], st, e.b, e.start);
                  end
               end
            end
         end
      end
   end

   initial begin : main
      reset       = 1'b1;
      value_valid = 1'b0;
      value_in    = 8'h00;
      @(negedge clk);
      do_reset();

      // single values: 0xA5 (165) and 7
      tick(1'b1, 8'hA5);
      wait_idle();
      tick(1'b1, 8'd7);
      wait_idle();

      // three strobes during one message: 10 sent, 20 pending, 30 dropped
      tick(1'b1, 8'd10);
      repeat (20) tick(1'b0, 8'h00);
      tick(1'b1, 8'd20);
      repeat (30) tick(1'b0, 8'h00);
      tick(1'b1, 8'd30);
      wait_idle();
      chk("overrun_sticky", longint'(overrun), 1);
      do_reset();

      // strobe in the cycle the pending value is consumed
      tick(1'b1, 8'd99);
      tick(1'b1, 8'd55);
      chk("ready_after_consume", longint'(ready), 1);
      chk("overrun_consume_cycle", longint'(overrun), 1);
      wait_idle();
      do_reset();

      // boundaries 0 and 255, then reset inside the second character of 255
      tick(1'b1, 8'd0);
      wait_idle();
      tick(1'b1, 8'd255);
      repeat (60) tick(1'b0, 8'h00);
      wait_tx_low();
      do_reset();
      tick(1'b1, 8'd42);
      wait_idle();

      // randomized traffic with occasional resets
      for (int i = 0; i < 20000; i++) begin
         if ($urandom_range(0, 1999) == 0)
            do_reset();
         tick(($urandom_range(0, 149) == 0), 8'($urandom_range(0, 255)));
      end
      wait_idle();

      chk("queue_empty", longint'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_uart_tx.md
# seq_uart_tx

Serial reporting stage downstream of the sequence generator.
- Accepts each new 8-bit value of the currently selected sequence (the `uo_out` mux result) as a one-cycle strobe.
- Converts the value to ASCII decimal and transmits it over a single 8N1 UART line, terminated by CR LF.
- Holds one pending value while a transmission is in progress, so the generator never stalls.
- Flags any value lost to overflow.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: clk cycles per UART bit (115200 baud at 50 MHz); legal range 2..65535.

Ports:
- `clk`  in  1  : single system clock; all logic on its rising edge.
- `reset`  in  1  : asynchronous, active-high reset.
- `value_in`  in  8  : unsigned sequence value, sampled when `value_valid` is high.
- `value_valid`  in  1  : one-clk strobe, synchronous to `clk`, generated upstream on each sequence step.
- `ready`  out  1  : pending register empty; a strobe this cycle will be accepted.
- `tx`  out  1  : UART line, idle high.
- `busy`  out  1  : high from conversion start until the LF stop bit completes.
- `overrun`  out  1  : sticky; set when a strobe arrives with `ready` low.

## Operation
Reset values:
- `tx`=1, `busy`=0, `ready`=1, `overrun`=0.
- Pending register empty; FSM in IDLE.
- Reset mid-frame aborts immediately: no partial character is completed.

Pending register (one deep):
- `value_valid` && `ready`: `value_in` is loaded and `ready` falls at that edge.
- `value_valid` && !`ready`: value dropped; `overrun` set until reset.
- `ready` is a registered-state decode: a strobe arriving in the same cycle the FSM consumes the pending value is dropped and flagged.

FSM states:
- **IDLE**: pending full → load converter, clear pending, go to CONVERT.
- **CONVERT**: 8 iterations of shift-add-3 binary-to-BCD (one per clk) → SEND, character index 0.
- **SEND**: characters in order: hundreds, tens, ones, 0x0D, 0x0A.
  - Each frame is a start bit (0), 8 data bits LSB first, then a stop bit (1).
  - Each bit lasts exactly `CLKS_PER_BIT` cycles.
  - No idle gap between frames.
  - After the LF stop bit → IDLE.

Arithmetic:
- Value range 0..255, so hundreds digit is 0..2.
- Each BCD digit is 4 bits; ASCII code = 0x30 + digit.
- Baud counter width = clog2(`CLKS_PER_BIT`); it wraps to 0 at `CLKS_PER_BIT`-1.

## Timing
- Accepting edge E0: pending loaded.
- E1: IDLE→CONVERT.
- E9: last BCD iteration.
- E10: `tx` falls (start bit of first character); `busy` is high from E1.
- Full 3-digit message: 50 × `CLKS_PER_BIT` cycles from E10 to the end of the LF stop bit.
- `busy` falls at the same edge FSM re-enters IDLE.
- If the pending register is full at that edge, the next conversion starts one edge later. `busy` therefore pulses low for exactly one cycle between back-to-back messages.
- `ready` rises at the edge the FSM consumes pending (E1 for an idle block).

## Configuration
- `SEQ_UART_LZS_EN` defined: leading zeros suppressed.
  - Hundreds digit skipped if 0.
  - Tens digit skipped if hundreds and tens are both 0.
  - The ones digit is always sent.
  - Message length is 3–5 characters.
- `SEQ_UART_LZS_EN` undefined: always exactly three digits, for a 5-character message.

## Structure
- Package `seq_uart_pkg` holds:
  - the FSM state enum (IDLE, CONVERT, SEND);
  - constants: ASCII_ZERO=0x30, ASCII_CR=0x0D, ASCII_LF=0x0A, FRAME_BITS=10, MSG_CHARS=5.
- One sub-module, `bin2bcd_seq`: an iterative 8-bit double-dabble converter with start/done and a 12-bit BCD output, instantiated in the CONVERT path.
- Baud counter, bit counter, character index, and shift register live in the top module.

## Test plan
- Reset with `CLKS_PER_BIT`=4 → `tx`=1, `busy`=0, `ready`=1, `overrun`=0. Assert reset mid-run → `tx` high within the same cycle, asynchronously.
- 0xA5 strobe → bytes 0x31 0x36 0x35 0x0D 0x0A decoded on `tx`. Start bit at E0+10; message lasts 200 cycles.
- Value 7:
  - with `SEQ_UART_LZS_EN` → 0x37 0x0D 0x0A (120 cycles);
  - without → 0x30 0x30 0x37 0x0D 0x0A.
- Three strobes (10, 20, 30) during one message → 10 and 20 transmitted in order, 30 dropped, `overrun`=1 and held until reset.
- Strobe in the exact cycle FSM consumes pending → value dropped, `overrun`=1; `ready` high on the following cycle.
- Values 0 and 255:
  - with LZS → "0\r\n" and "255\r\n";
  - reset mid second character, then strobe 42 → clean "42\r\n" with no stray bits.
